// File: rtl/psum_acc_sfu.sv
// psum_acc_sfu: multi-pass partial-sum accumulator with per-channel
// saturating adds and a registered, optionally ReLU'd, drain stage.
module psum_acc_sfu #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 16,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int VW     = COL * PSUM_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] cfg_npix,
  input  logic [3:0]    cfg_npass,
  input  logic          cfg_relu,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PSUM_BW-1:0] SMAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] SMIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] npix_q, pix_q;
  logic [3:0]    npass_q, pass_q;
  logic          relu_q;
  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] rd_vec, acc_vec, drn_vec;
  logic          cfg_ok, start_ok, in_fire;
  logic          pix_last, pass_last, load, last;

  function automatic logic [PSUM_BW-1:0] sat_add(
    input logic [PSUM_BW-1:0] a,
    input logic [PSUM_BW-1:0] b
  );
    logic [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1])
      sat_add = s[PSUM_BW] ? SMIN : SMAX;
    else
      sat_add = s[PSUM_BW-1:0];
  endfunction

  assign cfg_ok    = (cfg_npix != '0) &&
                     (cfg_npix <= CW'(DEPTH)) &&
                     (cfg_npass != '0);
  assign start_ok  = start && (state_q == IDLE) && cfg_ok;
  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign in_fire   = in_valid && in_ready;
  assign pix_last  = (pix_q == npix_q - CW'(1));
  assign pass_last = (pass_q == npass_q - 4'd1);
  // pix_q doubles as the drain read pointer; pix_q == npix_q means all loaded
  assign load      = (state_q == DRAIN) && (pix_q < npix_q) &&
                     (!out_valid || out_ready);
  assign last      = (state_q == DRAIN) && out_valid && out_ready &&
                     (pix_q == npix_q);
  assign rd_vec    = mem[pix_q[AW-1:0]];

  always_comb begin
    acc_vec = in_data;
    drn_vec = rd_vec;
    for (int c = 0; c < COL; c++) begin
      if (pass_q != '0)
        acc_vec[c*PSUM_BW +: PSUM_BW] =
          sat_add(rd_vec[c*PSUM_BW +: PSUM_BW],
                  in_data[c*PSUM_BW +: PSUM_BW]);
      if (relu_q && rd_vec[c*PSUM_BW + PSUM_BW - 1])
        drn_vec[c*PSUM_BW +: PSUM_BW] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ACC;
      ACC:     if (in_fire && pix_last && pass_last) state_d = DRAIN;
      DRAIN:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[pix_q[AW-1:0]] <= acc_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npix_q    <= '0;
      npass_q   <= '0;
      relu_q    <= 1'b0;
      pix_q     <= '0;
      pass_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= start && (state_q == IDLE) && !cfg_ok;
      if (start_ok) begin
        npix_q  <= cfg_npix;
        npass_q <= cfg_npass;
        relu_q  <= cfg_relu;
        pix_q   <= '0;
        pass_q  <= '0;
      end
      if (in_fire) begin
        if (pix_last) begin
          pix_q  <= '0;
          pass_q <= pass_last ? 4'd0 : pass_q + 4'd1;
        end else begin
          pix_q <= pix_q + CW'(1);
        end
      end
      if (load) begin
        out_data  <= drn_vec;
        out_valid <= 1'b1;
        pix_q     <= pix_q + CW'(1);
      end else if (last) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
        pix_q     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_psum_acc_sfu.sv
// tb_psum_acc_sfu: scoreboard bench for psum_acc_sfu; expected vectors come
// from an integer reference model of the multi-pass accumulation.
module tb_psum_acc_sfu;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = COL * BW;
  localparam int MAXV  = (1 << (BW-1)) - 1;
  localparam int MINV  = -(1 << (BW-1));

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_npix = '0;
  logic [3:0]    cfg_npass = '0;
  logic          cfg_relu = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          busy, done, cfg_err;

  int checks = 0;
  int failures = 0;
  int stall_err = 0;
  bit timeout, drv_timeout, done_ok;
  logic [VW-1:0] in_q[$];
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got_q[$];

  psum_acc_sfu #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_npix(cfg_npix), .cfg_npass(cfg_npass), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic model(input int npix, input int npass, input bit relu);
    logic [VW-1:0] acc [DEPTH];
    logic [VW-1:0] v;
    int a, s;
    for (int p = 0; p < npass; p++)
      for (int x = 0; x < npix; x++) begin
        v = in_q[p*npix + x];
        for (int c = 0; c < COL; c++) begin
          a = $signed(v[c*BW +: BW]);
          if (p == 0) s = a;
          else s = $signed(acc[x][c*BW +: BW]) + a;
          if (s > MAXV) s = MAXV;
          if (s < MINV) s = MINV;
          acc[x][c*BW +: BW] = BW'(s);
        end
      end
    for (int x = 0; x < npix; x++) begin
      v = acc[x];
      for (int c = 0; c < COL; c++)
        if (relu && v[c*BW + BW - 1]) v[c*BW +: BW] = '0;
      exp_q.push_back(v);
    end
  endtask

  task automatic start_job(input int npix, input int npass, input bit relu);
    @(negedge clk);
    cfg_npix = CW'(npix); cfg_npass = 4'(npass); cfg_relu = relu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int gap_pct);
    int guard;
    drv_timeout = 0;
    for (int k = 0; k < in_q.size(); k++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = in_q[k];
      guard = 0;
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin drv_timeout = 1; break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_pct);
    int cyc = 0;
    int cnt = 0;
    bit stalled = 0;
    logic [VW-1:0] pd = '0;
    timeout = 0;
    done_ok = 0;
    while (cnt < n) begin
      @(negedge clk);
      if (stalled && (!out_valid || out_data !== pd)) stall_err++;
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        cnt++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        pd = out_data;
      end
      cyc++;
      if (cyc > 3000) begin timeout = 1; break; end
    end
    @(negedge clk);
    done_ok = done && !busy;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #23;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b in_ready=%b out_valid=%b exp=0/0/0",
               busy, in_ready, out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
    checks++;
    if (done !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse done=%b cfg_err=%b exp=0/0", done, cfg_err);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [VW-1:0] e, g;
    in_q.delete();
    for (int k = 0; k < 12; k++) in_q.push_back(splat(k));
    model(4, 3, 0);
    start_job(4, 3, 0);
    fork
      drive(0);
      collect(4, 0);
    join
    checks++;
    if (got_q.size() != 4 || got_q[0] !== splat(12) || got_q[3] !== splat(21)) begin
      failures++;
      $display("FAIL basic_const n=%0d got0=%h exp0=%h", got_q.size(),
               got_q.size() > 0 ? got_q[0] : '0, splat(12));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL basic_out got=%h exp=%h", g, e);
      end
    end
    checks++;
    if (timeout || drv_timeout || !done_ok || got_q.size() != 0) begin
      failures++;
      $display("FAIL basic_done to=%b/%b done=%b extra=%0d exp=0/0/1/0",
               timeout, drv_timeout, done_ok, got_q.size());
    end
  endtask

  task automatic test_saturation;
    logic [VW-1:0] v, e, g;
    in_q.delete();
    for (int p = 0; p < 2; p++) begin
      v = splat(p == 0 ? 100 : -350);
      v[0 +: BW] = BW'(30000);
      v[BW +: BW] = BW'(-30000);
      in_q.push_back(v);
    end
    model(1, 2, 0);
    start_job(1, 2, 0);
    fork
      drive(0);
      collect(1, 0);
    join
    checks++;
    if (got_q.size() != 1 || got_q[0][0 +: BW] !== 16'h7fff ||
        got_q[0][BW +: BW] !== 16'h8000) begin
      failures++;
      $display("FAIL sat_clamp n=%0d got=%h exp ch0=7fff ch1=8000",
               got_q.size(), got_q.size() > 0 ? got_q[0][2*BW-1:0] : '0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL sat_out got=%h exp=%h", g, e);
      end
    end
    checks++;
    if (timeout || drv_timeout || !done_ok) begin
      failures++;
      $display("FAIL sat_done to=%b/%b done=%b exp=0/0/1",
               timeout, drv_timeout, done_ok);
    end
  endtask

  task automatic test_relu;
    logic [VW-1:0] v, e, g;
    in_q.delete();
    in_q.push_back(splat(-5));
    v = splat(7);
    v[2*BW +: BW] = BW'(-1);
    in_q.push_back(v);
    model(2, 1, 1);
    start_job(2, 1, 1);
    fork
      drive(0);
      collect(2, 0);
    join
    checks++;
    if (got_q.size() != 2 || got_q[0] !== splat(0) ||
        got_q[1][0 +: BW] !== 16'd7) begin
      failures++;
      $display("FAIL relu_const n=%0d got0=%h exp0=0",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL relu_out got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_stall;
    logic [VW-1:0] v, e, g;
    in_q.delete();
    for (int k = 0; k < DEPTH*3; k++) begin
      for (int c = 0; c < COL; c++) v[c*BW +: BW] = BW'($urandom_range(0, 65535));
      in_q.push_back(v);
    end
    for (int run = 0; run < 2; run++) begin
      model(DEPTH, 3, 1);
      stall_err = 0;
      start_job(DEPTH, 3, 1);
      fork
        drive(run == 0 ? 0 : 40);
        collect(DEPTH, run == 0 ? 0 : 50);
      join
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL stall_out run=%0d got=%h exp=%h", run, g, e);
        end
      end
      checks++;
      if (stall_err != 0 || timeout || drv_timeout || !done_ok) begin
        failures++;
        $display("FAIL stall_hold run=%0d unstable=%0d to=%b/%b done=%b exp=0/0/0/1",
                 run, stall_err, timeout, drv_timeout, done_ok);
      end
    end
  endtask

  task automatic test_cfg_err;
    logic [VW-1:0] e, g, a, b;
    int bad_npix[3] = '{0, DEPTH+1, 2};
    int bad_npass[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      start_job(bad_npix[i], bad_npass[i], 0);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_%0d cfg_err=%b busy=%b exp=1/0", i, cfg_err, busy);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_pulse_%0d cfg_err=%b busy=%b exp=0/0", i, cfg_err, busy);
      end
    end
    a = splat(-1234);
    b = splat(4321);
    in_q.delete();
    in_q.push_back(a);
    in_q.push_back(b);
    model(2, 1, 0);
    start_job(2, 1, 0);
    in_q.delete();
    in_q.push_back(a);
    drive(0);
    cfg_npix = CW'(5); cfg_npass = 4'd4; cfg_relu = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_start cfg_err=%b busy=%b in_ready=%b exp=0/1/1",
               cfg_err, busy, in_ready);
    end
    in_q.delete();
    in_q.push_back(b);
    fork
      drive(0);
      collect(2, 0);
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL busy_out got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_reset_drain;
    logic [VW-1:0] e, g;
    int guard = 0;
    in_q.delete();
    for (int k = 0; k < 3; k++) in_q.push_back(splat(100 + k));
    start_job(3, 1, 0);
    drive(0);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_reach out_valid=%b exp=1", out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL drain_reset out_valid=%b busy=%b data=%h exp=0/0/0",
               out_valid, busy, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    in_q.delete();
    in_q.push_back(splat(9));
    model(1, 1, 0);
    start_job(1, 1, 0);
    fork
      drive(0);
      collect(1, 0);
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checks++;
      if (g !== e || g !== splat(9)) begin
        failures++;
        $display("FAIL post_reset got=%h exp=%h", g, e);
      end
    end
    checks++;
    if (timeout || drv_timeout || !done_ok) begin
      failures++;
      $display("FAIL post_reset_done to=%b/%b done=%b exp=0/0/1",
               timeout, drv_timeout, done_ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_stall();
    test_cfg_err();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
